// File: rtl/jos_pkg.sv
// jos_pkg: shared types for the serial transmit path.
//   ser_state_t : frame FSM state, 2-bit encoding
package jos_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } ser_state_t;

endpackage

// File: rtl/bit_down_counter.sv
// bit_down_counter: loadable down counter with zero flag. Stops at zero
// instead of wrapping, so a stray decrement can never restart a frame.
//   clk      : clock
//   clr      : synchronous active-high clear (count -> 0)
//   i_ld     : load i_ld_val (takes priority over i_dec)
//   i_ld_val : value to load
//   i_dec    : decrement by one when nonzero
//   o_zero   : count == 0
module bit_down_counter #(
  parameter int width = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             i_ld,
  input  logic [width-1:0] i_ld_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [width-1:0] r_cnt;

  assign o_zero = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (clr)                  r_cnt <= '0;
    else if (i_ld)            r_cnt <= i_ld_val;
    else if (i_dec && !o_zero) r_cnt <= r_cnt - 1'b1;
  end

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out transmitter. One word per frame is
// accepted on load while ready, shifted out one bit per clk with ser_en,
// optionally followed by an even-parity bit, then a one-cycle done pulse.
//   clk    : clock
//   clr    : synchronous active-high reset, beats every other input
//   load   : frame request, accepted only while ready
//   data_i : word to send, sampled only on an accepted load
//   ready  : IDLE, load accepted this cycle
//   busy   : frame in progress (SHIFT/PARITY/DONE)
//   ser_o  : serial bit, 0 when ser_en=0
//   ser_en : ser_o carries a frame bit
//   done   : one-cycle pulse after the last frame bit
// All outputs are decoded from registers only.
module piso_serializer
  import jos_pkg::*;
#(
  parameter int width     = 16,
  parameter int MSB_FIRST = 1,
  parameter int PARITY_EN = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [width-1:0] data_i,
  output logic             ready,
  output logic             busy,
  output logic             ser_o,
  output logic             ser_en,
  output logic             done
);

  localparam int CW = $clog2(width);

  ser_state_t       r_state, w_next;
  logic [width-1:0] r_sreg;
  logic             r_par;
  logic             w_bit, w_ld, w_cnt_zero;

  assign w_ld  = (r_state == IDLE) && load;
  assign w_bit = (MSB_FIRST != 0) ? r_sreg[width-1] : r_sreg[0];

  bit_down_counter #(.width(CW)) u_cnt (
    .clk      (clk),
    .clr      (clr),
    .i_ld     (w_ld),
    .i_ld_val (CW'(width - 1)),
    .i_dec    (r_state == SHIFT),
    .o_zero   (w_cnt_zero)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (load) w_next = SHIFT;
      SHIFT:   if (w_cnt_zero) w_next = (PARITY_EN != 0) ? PARITY : DONE;
      PARITY:  w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= IDLE;
      r_sreg  <= '0;
      r_par   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_ld) begin
        r_sreg <= data_i;
        r_par  <= 1'b0;
      end else if (r_state == SHIFT) begin
        r_par <= r_par ^ w_bit;
        // Move the next bit toward the output end, zero-filling behind it.
        r_sreg <= (MSB_FIRST != 0) ? {r_sreg[width-2:0], 1'b0}
                                   : {1'b0, r_sreg[width-1:1]};
      end
    end
  end

  assign ready  = (r_state == IDLE);
  assign busy   = (r_state != IDLE);
  assign done   = (r_state == DONE);
  assign ser_en = (r_state == SHIFT) || (r_state == PARITY);
  assign ser_o  = (r_state == SHIFT)  ? w_bit :
                  (r_state == PARITY) ? r_par : 1'b0;

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed checks of two serializer configurations.
//   u0 : width=16, MSB_FIRST=1, PARITY_EN=0
//   u1 : width=16, MSB_FIRST=0, PARITY_EN=1
module tb_piso_serializer;

  logic        clk = 1'b0;
  logic        clr;
  logic [1:0]  load;
  logic [15:0] data0, data1;
  logic [1:0]  ready, busy, ser_o, ser_en, done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  piso_serializer #(.width(16), .MSB_FIRST(1), .PARITY_EN(0)) u0 (
    .clk(clk), .clr(clr), .load(load[0]), .data_i(data0),
    .ready(ready[0]), .busy(busy[0]), .ser_o(ser_o[0]),
    .ser_en(ser_en[0]), .done(done[0])
  );

  piso_serializer #(.width(16), .MSB_FIRST(0), .PARITY_EN(1)) u1 (
    .clk(clk), .clr(clr), .load(load[1]), .data_i(data1),
    .ready(ready[1]), .busy(busy[1]), .ser_o(ser_o[1]),
    .ser_en(ser_en[1]), .done(done[1])
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check all five outputs of instance d against expected values.
  task automatic chk_out(input string tag, input int d, input int rdy, input int bsy,
                         input int so, input int se, input int dn);
    chk({tag, ".ready"},  int'(ready[d]),  rdy);
    chk({tag, ".busy"},   int'(busy[d]),   bsy);
    chk({tag, ".ser_o"},  int'(ser_o[d]),  so);
    chk({tag, ".ser_en"}, int'(ser_en[d]), se);
    chk({tag, ".done"},   int'(done[d]),   dn);
  endtask

  // Send one word on instance d (must be idle) and check the whole frame.
  task automatic send_frame(input string tag, input int d, input logic [15:0] w,
                            input int exp_par);
    int b;
    if (d == 0) begin load[0] = 1'b1; data0 = w; end
    else        begin load[1] = 1'b1; data1 = w; end
    tick();
    load = '0;
    for (int i = 0; i < 16; i++) begin
      b = (d == 0) ? int'(w[15 - i]) : int'(w[i]);
      chk($sformatf("%s.bit%0d", tag, i), int'(ser_o[d]), b);
      chk($sformatf("%s.en%0d", tag, i), int'(ser_en[d]), 1);
      chk($sformatf("%s.nodone%0d", tag, i), int'(done[d]), 0);
      tick();
    end
    if (d == 1) begin
      chk({tag, ".par_en"}, int'(ser_en[1]), 1);
      chk({tag, ".par"},    int'(ser_o[1]),  exp_par);
      tick();
    end
    chk_out({tag, ".done"}, d, 0, 1, 0, 0, 1);
    tick();
    chk_out({tag, ".idle"}, d, 1, 0, 0, 0, 0);
  endtask

  int dn_cnt, en_cnt, one_cnt;
  logic [15:0] words [3];

  initial begin
    clr = 1'b1; load = '0; data0 = '0; data1 = '0;

    // 1. reset for 3 cycles, then idle
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("rst%0d", i), 0, 1, 0, 0, 0, 0);
    end
    chk_out("rst_u1", 1, 1, 0, 0, 0, 0);
    clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_out($sformatf("idle%0d", i), 0, 1, 0, 0, 0, 0);
    end

    // 2. MSB first, no parity
    send_frame("msb_a5c3", 0, 16'hA5C3, 0);

    // 3. LSB first with even parity
    send_frame("lsb_0001", 1, 16'h0001, 1);
    send_frame("lsb_a5c3", 1, 16'hA5C3, 0);

    // 4. load during SHIFT is ignored
    load[0] = 1'b1; data0 = 16'h0000;
    tick();
    load[0] = 1'b0;
    dn_cnt = 0; en_cnt = 0; one_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 3) begin load[0] = 1'b1; data0 = 16'hFFFF; end
      else        load[0] = 1'b0;
      if (ser_en[0]) en_cnt++;
      if (ser_o[0])  one_cnt++;
      if (done[0])   dn_cnt++;
      tick();
    end
    load[0] = 1'b0;
    chk("busy_load.ones", one_cnt, 0);
    chk("busy_load.bits", en_cnt, 16);
    chk("busy_load.dones", dn_cnt, 1);

    // 5. clr on the 5th bit aborts the frame
    tick();
    load[0] = 1'b1; data0 = 16'hFFFF;
    tick();
    load[0] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("abort.bit5", int'(ser_o[0]), 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk_out("abort", 0, 1, 0, 0, 0, 0);
    dn_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (done[0]) dn_cnt++;
      tick();
    end
    chk("abort.nodone", dn_cnt, 0);
    send_frame("after_abort", 0, 16'h8000, 0);

    // clr together with load: load ignored
    clr = 1'b1; load[0] = 1'b1; data0 = 16'h1111;
    tick();
    clr = 1'b0; load[0] = 1'b0;
    chk_out("clr_load", 0, 1, 0, 0, 0, 0);
    tick();
    chk("clr_load.idle", int'(ready[0]), 1);

    // 6. load held high: one frame per 18 cycles, data sampled only in IDLE
    words[0] = 16'h1234; words[1] = 16'hBEEF; words[2] = 16'h0F0F;
    load[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 18; c++) begin
        if (c == 0) begin
          chk($sformatf("stream%0d.ready", k), int'(ready[0]), 1);
          chk($sformatf("stream%0d.idle_en", k), int'(ser_en[0]), 0);
          data0 = words[k];
        end else begin
          data0 = 16'($urandom);
          if (c <= 16)
            chk($sformatf("stream%0d.bit%0d", k, c), int'(ser_o[0]), int'(words[k][16 - c]));
          else
            chk($sformatf("stream%0d.done", k), int'(done[0]), 1);
        end
        tick();
      end
    end
    load[0] = 1'b0;
    chk("stream.end_ready", int'(ready[0]), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
